// File: rtl/direct_mapped.sv
// ---------------------------------------------------------------------------
// direct_mapped
//   Direct-mapped, write-back, write-allocate cache between a single 32-bit
//   word requester and a word-wide external RAM with a strobe/valid handshake.
//   Hits finish one cycle after the lookup and may be issued back-to-back.
//   A miss writes back a dirty victim word by word, refills the line word by
//   word, then re-runs the lookup which now hits and completes the access.
//
//   Address layout (LSB up): byte [1:0] | word | index | tag.
//
// Ports
//   clk                in  rising-edge clock
//   rst                in  asynchronous reset, active low
//   cache_address      in  requester byte address (bits [1:0] ignored)
//   cache_rd/cache_wr  in  request strobes (read wins if both are high)
//   cache_byte_enable  in  write byte lanes, bit i -> data[8i+7:8i]
//   cache_data_wr      in  write data
//   cache_data_out     out read data, valid while cache_ready=1 on a read
//   cache_ready        out one-cycle completion pulse per accepted request
//   ram_address        out word-aligned RAM byte address
//   ram_rd/ram_wr      out one-cycle RAM strobes, one per word
//   ram_data_wr        out RAM write data
//   ram_data_rd        in  RAM read data, valid with ram_data_valid
//   ram_data_valid     in  RAM completion of the last strobe
//
// Optional build macro
//   DIRECT_MAPPED_PERF_CNT_EN : adds hit_count / miss_count outputs.
// ---------------------------------------------------------------------------
module direct_mapped #(
  parameter int ADDRESS_WIDTH     = 16,
  parameter int INDEX_WIDTH       = 3,
  parameter int WORD_OFFSET_WIDTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ADDRESS_WIDTH-1:0] cache_address,
  input  logic                     cache_rd,
  input  logic                     cache_wr,
  input  logic [3:0]               cache_byte_enable,
  input  logic [31:0]              cache_data_wr,
  output logic [31:0]              cache_data_out,
  output logic                     cache_ready,
  output logic [ADDRESS_WIDTH-1:0] ram_address,
  output logic                     ram_rd,
  output logic                     ram_wr,
  output logic [31:0]              ram_data_wr,
  input  logic [31:0]              ram_data_rd,
  input  logic                     ram_data_valid
`ifdef DIRECT_MAPPED_PERF_CNT_EN
  ,
  output logic [31:0]              hit_count,
  output logic [31:0]              miss_count
`endif
);

  localparam int OFFSET_LSB = 2;
  localparam int INDEX_LSB  = OFFSET_LSB + WORD_OFFSET_WIDTH;
  localparam int TAG_LSB    = INDEX_LSB + INDEX_WIDTH;
  localparam int TAG_WIDTH  = ADDRESS_WIDTH - TAG_LSB;
  localparam int NUM_LINES  = 1 << INDEX_WIDTH;
  localparam int NUM_WORDS  = 1 << WORD_OFFSET_WIDTH;

  localparam logic [WORD_OFFSET_WIDTH-1:0] FIRST_WORD = '0;
  localparam logic [WORD_OFFSET_WIDTH-1:0] LAST_WORD  = '1;
  localparam logic [WORD_OFFSET_WIDTH-1:0] WORD_STEP  = WORD_OFFSET_WIDTH'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COMPARE,
    S_WRITEBACK,
    S_FILL
  } state_t;

  // -------------------------------------------------------------------------
  // Storage
  // -------------------------------------------------------------------------
  logic [NUM_LINES-1:0] r_valid;
  logic [NUM_LINES-1:0] r_dirty;
  logic [TAG_WIDTH-1:0] r_tag  [NUM_LINES];
  logic [31:0]          r_data [NUM_LINES][NUM_WORDS];

  // Captured request; byte-in-word bits are not kept.
  logic [ADDRESS_WIDTH-1:OFFSET_LSB] r_req_addr;
  logic [31:0]                       r_req_data;
  logic [3:0]                        r_req_be;
  logic                              r_req_wr;

  state_t                       r_state;
  state_t                       w_state_next;
  logic [WORD_OFFSET_WIDTH-1:0] r_word_cnt;

  // -------------------------------------------------------------------------
  // Lookup of the captured request
  // -------------------------------------------------------------------------
  logic [INDEX_WIDTH-1:0]       w_index;
  logic [TAG_WIDTH-1:0]         w_tag;
  logic [WORD_OFFSET_WIDTH-1:0] w_word;
  logic                         w_line_valid;
  logic                         w_line_dirty;
  logic                         w_hit;
  logic                         w_new_req;
  logic                         w_last_word;
  logic [31:0]                  w_cur_word;
  logic [31:0]                  w_merged;
  logic                         w_unused_byte_bits;

  assign w_index      = r_req_addr[TAG_LSB-1:INDEX_LSB];
  assign w_tag        = r_req_addr[ADDRESS_WIDTH-1:TAG_LSB];
  assign w_word       = r_req_addr[INDEX_LSB-1:OFFSET_LSB];
  assign w_line_valid = r_valid[w_index];
  assign w_line_dirty = r_dirty[w_index];
  assign w_hit        = w_line_valid && (r_tag[w_index] == w_tag);
  assign w_new_req    = cache_rd || cache_wr;
  assign w_last_word  = (r_word_cnt == LAST_WORD);
  assign w_cur_word   = r_data[w_index][w_word];

  // Requests are word-granular; the byte offset is deliberately dropped.
  assign w_unused_byte_bits = ^cache_address[OFFSET_LSB-1:0];

  always_comb begin
    w_merged = w_cur_word;
    for (int b = 0; b < 4; b++) begin
      if (r_req_be[b]) begin
        w_merged[8*b +: 8] = r_req_data[8*b +: 8];
      end
    end
  end

  // -------------------------------------------------------------------------
  // Controller: next state and per-edge actions
  // -------------------------------------------------------------------------
  logic                         w_accept;     // capture a new request this edge
  logic                         w_complete;   // hit completes this edge
  logic                         w_wb_issue;   // launch a RAM write strobe
  logic                         w_fill_issue; // launch a RAM read strobe
  logic [WORD_OFFSET_WIDTH-1:0] w_issue_word; // word the launched strobe targets
  logic                         w_wb_done;    // last write-back word acknowledged
  logic                         w_fill_done;  // last refill word arrived

  // NOTE: every output of a combinational block gets a default before the
  // case statement; a path that leaves one unassigned would infer a latch.
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_complete   = 1'b0;
    w_wb_issue   = 1'b0;
    w_fill_issue = 1'b0;
    w_issue_word = FIRST_WORD;
    w_wb_done    = 1'b0;
    w_fill_done  = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_new_req) begin
          w_accept     = 1'b1;
          w_state_next = S_COMPARE;
        end
      end

      S_COMPARE: begin
        if (w_hit) begin
          w_complete = 1'b1;
          // A hit frees the request registers, so a new request can be
          // taken on the same edge for back-to-back hits.
          if (w_new_req) begin
            w_accept     = 1'b1;
            w_state_next = S_COMPARE;
          end else begin
            w_state_next = S_IDLE;
          end
        end else if (w_line_valid && w_line_dirty) begin
          w_wb_issue   = 1'b1;
          w_state_next = S_WRITEBACK;
        end else begin
          w_fill_issue = 1'b1;
          w_state_next = S_FILL;
        end
      end

      S_WRITEBACK: begin
        if (ram_data_valid) begin
          if (w_last_word) begin
            // Victim fully written; start the refill on the same edge.
            w_wb_done    = 1'b1;
            w_fill_issue = 1'b1;
            w_state_next = S_FILL;
          end else begin
            w_wb_issue   = 1'b1;
            w_issue_word = r_word_cnt + WORD_STEP;
          end
        end
      end

      S_FILL: begin
        if (ram_data_valid) begin
          if (w_last_word) begin
            w_fill_done  = 1'b1;
            w_state_next = S_COMPARE;
          end else begin
            w_fill_issue = 1'b1;
            w_issue_word = r_word_cnt + WORD_STEP;
          end
        end
      end

      default: w_state_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // -------------------------------------------------------------------------
  // Control registers and outputs
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid        <= '0;
      r_dirty        <= '0;
      r_req_addr     <= '0;
      r_req_data     <= '0;
      r_req_be       <= '0;
      r_req_wr       <= 1'b0;
      r_word_cnt     <= FIRST_WORD;
      cache_ready    <= 1'b0;
      cache_data_out <= '0;
      ram_rd         <= 1'b0;
      ram_wr         <= 1'b0;
      ram_address    <= '0;
      ram_data_wr    <= '0;
    end else begin
      // Strobes and completion are single-cycle by construction.
      cache_ready <= w_complete;
      ram_rd      <= w_fill_issue;
      ram_wr      <= w_wb_issue;

      if (w_complete && !r_req_wr) begin
        cache_data_out <= w_cur_word;
      end

      if (w_wb_issue) begin
        ram_address <= {r_tag[w_index], w_index, w_issue_word, 2'b00};
        ram_data_wr <= r_data[w_index][w_issue_word];
      end else if (w_fill_issue) begin
        ram_address <= {w_tag, w_index, w_issue_word, 2'b00};
      end

      if (w_wb_issue || w_fill_issue) begin
        r_word_cnt <= w_issue_word;
      end

      if (w_complete && r_req_wr) begin
        r_dirty[w_index] <= 1'b1;
      end
      if (w_wb_done) begin
        r_dirty[w_index] <= 1'b0;
      end
      if (w_fill_done) begin
        r_valid[w_index] <= 1'b1;
        r_dirty[w_index] <= 1'b0;
      end

      if (w_accept) begin
        r_req_addr <= cache_address[ADDRESS_WIDTH-1:OFFSET_LSB];
        r_req_data <= cache_data_wr;
        r_req_be   <= cache_byte_enable;
        r_req_wr   <= !cache_rd;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Tag and data arrays
  // -------------------------------------------------------------------------
  logic                         w_mem_we;
  logic [WORD_OFFSET_WIDTH-1:0] w_mem_word;
  logic [31:0]                  w_mem_wdata;

  assign w_mem_we    = ((r_state == S_FILL) && ram_data_valid) || (w_complete && r_req_wr);
  assign w_mem_word  = (r_state == S_FILL) ? r_word_cnt : w_word;
  assign w_mem_wdata = (r_state == S_FILL) ? ram_data_rd : w_merged;

  // NOTE: the arrays have no reset; the valid bits decide whether their
  // contents mean anything, so clearing them would only cost logic.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_data[w_index][w_mem_word] <= w_mem_wdata;
    end
    if (w_fill_done) begin
      r_tag[w_index] <= w_tag;
    end
  end

  // -------------------------------------------------------------------------
  // Optional performance counters
  // -------------------------------------------------------------------------
`ifdef DIRECT_MAPPED_PERF_CNT_EN
  // Marks the lookup that follows a refill so it is not counted as a hit.
  logic r_refilled;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_count  <= '0;
      miss_count <= '0;
      r_refilled <= 1'b0;
    end else begin
      if (w_fill_done) begin
        r_refilled <= 1'b1;
      end else if (w_complete) begin
        r_refilled <= 1'b0;
      end
      if (w_complete && !r_refilled) begin
        hit_count <= hit_count + 32'd1;
      end
      if ((r_state == S_COMPARE) && !w_hit) begin
        miss_count <= miss_count + 32'd1;
      end
    end
  end
`else
  // Counters compiled out; the controller is unchanged.
`endif

endmodule

// File: tb/tb_direct_mapped.sv
// ---------------------------------------------------------------------------
// tb_direct_mapped
//   Self-checking bench for direct_mapped. A behavioural RAM answers every
//   strobe one cycle later; each byte of an unwritten RAM word w holds w[7:0].
//   Expected RAM strobes and expected cache completions are queued before a
//   request is driven and consumed as the DUT produces them.
// ---------------------------------------------------------------------------
module tb_direct_mapped;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] cache_address;
  logic        cache_rd;
  logic        cache_wr;
  logic [3:0]  cache_byte_enable;
  logic [31:0] cache_data_wr;
  logic [31:0] cache_data_out;
  logic        cache_ready;
  logic [15:0] ram_address;
  logic        ram_rd;
  logic        ram_wr;
  logic [31:0] ram_data_wr;
  logic [31:0] ram_data_rd    = 32'h0;
  logic        ram_data_valid = 1'b0;

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit          wr;
    logic [15:0] addr;
    logic [31:0] data;
  } ram_op_t;

  typedef struct {
    bit          is_rd;
    logic [31:0] data;
  } cache_exp_t;

  ram_op_t     ram_q[$];
  cache_exp_t  cache_q[$];
  logic [31:0] ram_mem [int];

  direct_mapped dut (
    .clk               (clk),
    .rst               (rst),
    .cache_address     (cache_address),
    .cache_rd          (cache_rd),
    .cache_wr          (cache_wr),
    .cache_byte_enable (cache_byte_enable),
    .cache_data_wr     (cache_data_wr),
    .cache_data_out    (cache_data_out),
    .cache_ready       (cache_ready),
    .ram_address       (ram_address),
    .ram_rd            (ram_rd),
    .ram_wr            (ram_wr),
    .ram_data_wr       (ram_data_wr),
    .ram_data_rd       (ram_data_rd),
    .ram_data_valid    (ram_data_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ram_word(input logic [15:0] a);
    int w;
    w = int'(a[15:2]);
    if (ram_mem.exists(w)) return ram_mem[w];
    return {4{a[9:2]}};
  endfunction

  // RAM model and RAM-side scoreboard, sampled on the falling edge.
  bit          pend      = 1'b0;
  logic [31:0] pend_data = 32'h0;
  bit          prev_rd   = 1'b0;
  bit          prev_wr   = 1'b0;

  always @(negedge clk) begin
    ram_op_t op;
    if (!rst) begin
      ram_data_valid = 1'b0;
      pend           = 1'b0;
      prev_rd        = 1'b0;
      prev_wr        = 1'b0;
    end else begin
      ram_data_valid = pend;
      ram_data_rd    = pend_data;
      pend           = ram_rd || ram_wr;
      if (ram_rd || ram_wr) begin
        check("ram_rd_wr_exclusive", 32'(ram_rd && ram_wr), 32'h0);
        check("ram_strobe_width", 32'((ram_rd && prev_rd) || (ram_wr && prev_wr)), 32'h0);
        check("ram_op_expected", 32'(ram_q.size() != 0), 32'h1);
        if (ram_q.size() != 0) begin
          op = ram_q.pop_front();
          check("ram_op_is_wr", 32'(ram_wr), 32'(op.wr));
          check("ram_addr", 32'(ram_address), 32'(op.addr));
          if (op.wr) check("ram_wdata", ram_data_wr, op.data);
        end
        if (ram_wr) ram_mem[int'(ram_address[15:2])] = ram_data_wr;
        else        pend_data = ram_word(ram_address);
      end
      prev_rd = ram_rd;
      prev_wr = ram_wr;
    end
  end

  // Cache-side scoreboard.
  always @(negedge clk) begin
    cache_exp_t e;
    if (rst && cache_ready) begin
      check("ready_expected", 32'(cache_q.size() != 0), 32'h1);
      if (cache_q.size() != 0) begin
        e = cache_q.pop_front();
        if (e.is_rd) check("rd_data", cache_data_out, e.data);
      end
    end
  end

  task automatic exp_fill(input logic [15:0] base);
    for (int i = 0; i < 4; i++) ram_q.push_back('{wr: 1'b0, addr: base + 16'(4 * i), data: 32'h0});
  endtask

  task automatic exp_wb(input logic [15:0] base, input logic [31:0] d0, input logic [31:0] d1,
                        input logic [31:0] d2, input logic [31:0] d3);
    ram_q.push_back('{wr: 1'b1, addr: base,          data: d0});
    ram_q.push_back('{wr: 1'b1, addr: base + 16'd4,  data: d1});
    ram_q.push_back('{wr: 1'b1, addr: base + 16'd8,  data: d2});
    ram_q.push_back('{wr: 1'b1, addr: base + 16'd12, data: d3});
  endtask

  task automatic exp_rd(input logic [31:0] d);
    cache_q.push_back('{is_rd: 1'b1, data: d});
  endtask

  task automatic exp_wr();
    cache_q.push_back('{is_rd: 1'b0, data: 32'h0});
  endtask

  // Drives one request at a falling edge and waits (bounded) for cache_ready.
  // Latency is the number of falling edges until cache_ready is seen.
  task automatic do_req(input string tag, input bit is_wr, input logic [15:0] addr,
                        input logic [31:0] data, input logic [3:0] be, input int exp_lat);
    int n;
    bit seen;
    n    = 0;
    seen = 1'b0;
    cache_address     = addr;
    cache_data_wr     = data;
    cache_byte_enable = be;
    cache_rd          = !is_wr;
    cache_wr          = is_wr;
    while (!seen && n < 100) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        cache_rd = 1'b0;
        cache_wr = 1'b0;
      end
      seen = cache_ready;
    end
    check({tag, "_done"}, 32'(seen), 32'h1);
    if (seen) check({tag, "_latency"}, n, exp_lat);
    check({tag, "_ram_q_empty"}, ram_q.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "bench timeout");
  end

  initial begin
    cache_address     = 16'h0;
    cache_rd          = 1'b0;
    cache_wr          = 1'b0;
    cache_byte_enable = 4'h0;
    cache_data_wr     = 32'h0;
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_cache_ready", 32'(cache_ready), 32'h0);
    check("rst_ram_rd", 32'(ram_rd), 32'h0);
    check("rst_ram_wr", 32'(ram_wr), 32'h0);
    check("rst_ram_address", 32'(ram_address), 32'h0);
    check("rst_ram_data_wr", ram_data_wr, 32'h0);
    check("rst_cache_data_out", cache_data_out, 32'h0);
    rst = 1'b1;
    @(negedge clk);

    // Cold read miss: clean fill of line 2.
    exp_fill(16'h0020);
    exp_rd(32'h08080808);
    do_req("rd_0020", 1'b0, 16'h0020, 32'h0, 4'h0, 11);

    // Write miss allocates line 3 and dirties it, no write-back.
    exp_fill(16'hD030);
    exp_wr();
    do_req("wr_D030", 1'b1, 16'hD030, 32'h00001234, 4'hF, 11);

    exp_fill(16'hA840);
    exp_rd(32'h10101010);
    do_req("rd_A840", 1'b0, 16'hA840, 32'h0, 4'h0, 11);

    // Back-to-back hits on two different lines.
    exp_rd(32'h0B0B0B0B);
    exp_rd(32'h11111111);
    cache_address = 16'h002C;
    cache_rd      = 1'b1;
    @(negedge clk);
    cache_address = 16'hA844;
    @(negedge clk);
    cache_rd = 1'b0;
    check("b2b_first_ready", 32'(cache_ready), 32'h1);
    @(negedge clk);
    check("b2b_second_ready", 32'(cache_ready), 32'h1);
    @(negedge clk);
    check("b2b_ready_low", 32'(cache_ready), 32'h0);
    check("b2b_ram_q_empty", ram_q.size(), 0);

    // Write hit.
    exp_wr();
    do_req("wrhit_D034", 1'b1, 16'hD034, 32'h00005678, 4'hF, 2);

    // Conflict on dirty line 3: write back, refill, then byte-0 merge.
    exp_wb(16'hD030, 32'h00001234, 32'h00005678, 32'h0E0E0E0E, 32'h0F0F0F0F);
    exp_fill(16'h3D30);
    exp_wr();
    do_req("wr_3D30", 1'b1, 16'h3D30, 32'h00000008, 4'h1, 19);

    exp_rd(32'h4C4C4C08);
    do_req("rd_3D30", 1'b0, 16'h3D30, 32'h0, 4'h0, 2);

    // Reset while the first refill strobe is on the bus.
    ram_q.push_back('{wr: 1'b0, addr: 16'h0050, data: 32'h0});
    cache_address = 16'h0050;
    cache_rd      = 1'b1;
    @(negedge clk);
    cache_rd = 1'b0;
    @(negedge clk);
    check("midfill_ram_rd_active", 32'(ram_rd), 32'h1);
    #2 rst = 1'b0;
    #1;
    check("midfill_ram_rd_drop", 32'(ram_rd), 32'h0);
    check("midfill_cache_ready", 32'(cache_ready), 32'h0);
    check("midfill_ram_address", 32'(ram_address), 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    check("midfill_ram_q_empty", ram_q.size(), 0);
    @(negedge clk);

    // Same address misses again and refills.
    exp_fill(16'h0050);
    exp_rd(32'h14141414);
    do_req("rd_0050_again", 1'b0, 16'h0050, 32'h0, 4'h0, 11);

    // Line 3 lost its dirty data at reset: clean refill from RAM, no write-back.
    exp_fill(16'h3D30);
    exp_rd(32'h4C4C4C4C);
    do_req("rd_3D30_after_rst", 1'b0, 16'h3D30, 32'h0, 4'h0, 11);

    repeat (4) @(negedge clk);
    check("end_cache_q_empty", cache_q.size(), 0);
    check("end_ram_q_empty", ram_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
